// File: rtl/alu_accum_seq.sv
// -----------------------------------------------------------------------------
// alu_accum_seq
//
// Registered accumulator ALU. The low half of the accumulator is fed back as
// operand A and the Data bus supplies operand B. Ops are requested with a
// valid/ready handshake. Most ops complete in the accept cycle. MUL runs a
// DATA_W-cycle shift-add sequence and holds Op_ready low while it runs.
//
// Parameters:
//   DATA_W        operand width (>= 2); the accumulator is 2*DATA_W bits
//
// Ports:
//   Clock         system clock, rising edge
//   Reset_b       asynchronous active-low reset
//   Data          operand B
//   Function      operation select (see op_e)
//   Op_valid      operation request
//   Op_ready      block can accept an op this cycle (combinational from state)
//   ALUout        accumulator register
//   Result_valid  one-cycle pulse after each ALUout write
//   Carry         carry / borrow / shift-out flag
//   Zero          high when ALUout == 0
//
// Build option:
//   ALU_SAT_EN    when defined, ADD saturates to 2^DATA_W-1 and SUB clamps
//                 to 0 on borrow. Carry still reports the overflow or borrow.
// -----------------------------------------------------------------------------
module alu_accum_seq #(
  parameter int DATA_W = 4
) (
  input  logic                  Clock,
  input  logic                  Reset_b,
  input  logic [DATA_W-1:0]     Data,
  input  logic [2:0]            Function,
  input  logic                  Op_valid,
  output logic                  Op_ready,
  output logic [2*DATA_W-1:0]   ALUout,
  output logic                  Result_valid,
  output logic                  Carry,
  output logic                  Zero
);

  localparam int ACC_W = 2 * DATA_W;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_SEXT = 3'b010,
    OP_OR   = 3'b011,
    OP_AND  = 3'b100,
    OP_SHL  = 3'b101,
    OP_MUL  = 3'b110,
    OP_HOLD = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_e;

  state_e state, state_next;

  logic [DATA_W-1:0] op_a;
  logic              accept;
  logic              is_mul;
  logic              mul_last;

  // Multiplier datapath
  logic [ACC_W-1:0]  mul_mcand;
  logic [DATA_W-1:0] mul_mplier;
  logic [ACC_W-1:0]  mul_prod;
  logic [ACC_W-1:0]  mul_prod_step;
  logic [CNT_W-1:0]  mul_cnt;

  // Single-cycle ALU results
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [2*ACC_W-1:0] shl_ext;
  logic              shl_big;
  logic [ACC_W-1:0]  alu_res;
  logic              alu_carry;

  assign op_a     = ALUout[DATA_W-1:0];
  assign Op_ready = (state == ST_IDLE);
  assign accept   = Op_valid && Op_ready;
  assign is_mul   = (op_e'(Function) == OP_MUL);
  assign mul_last = (state == ST_MUL) && (mul_cnt == CNT_W'(DATA_W - 1));
  assign Zero     = (ALUout == '0);

  // One shift-add iteration: add the shifted multiplicand when the current
  // multiplier LSB is set.
  assign mul_prod_step = mul_prod + (mul_mplier[0] ? mul_mcand : '0);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && is_mul) state_next = ST_MUL;
      ST_MUL:  if (mul_last)         state_next = ST_IDLE;
      default:                       state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case, so no
  //       path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    sum       = {1'b0, op_a} + {1'b0, Data};
    diff      = {1'b0, op_a} - {1'b0, Data};
    shl_ext   = {{ACC_W{1'b0}}, ALUout} << Data;
    shl_big   = (32'(Data) >= 32'(ACC_W));
    alu_res   = ALUout;
    alu_carry = Carry;

    case (op_e'(Function))
      OP_ADD: begin
        alu_carry = sum[DATA_W];
`ifdef ALU_SAT_EN
        alu_res = sum[DATA_W] ? {{DATA_W{1'b0}}, {DATA_W{1'b1}}}
                              : {{(DATA_W-1){1'b0}}, sum};
`else
        alu_res = {{(DATA_W-1){1'b0}}, sum};
`endif
      end
      OP_SUB: begin
        // The MSB of the (DATA_W+1)-bit difference is the borrow (A < Data).
        alu_carry = diff[DATA_W];
`ifdef ALU_SAT_EN
        alu_res = diff[DATA_W] ? '0 : {{(DATA_W-1){1'b0}}, diff};
`else
        alu_res = {{(DATA_W-1){diff[DATA_W]}}, diff};
`endif
      end
      OP_SEXT: begin
        alu_res   = {{DATA_W{op_a[DATA_W-1]}}, op_a};
        alu_carry = 1'b0;
      end
      OP_OR: begin
        alu_res   = {{(ACC_W-1){1'b0}}, |(op_a | Data)};
        alu_carry = 1'b0;
      end
      OP_AND: begin
        alu_res   = {{(ACC_W-1){1'b0}}, |(op_a & Data)};
        alu_carry = 1'b0;
      end
      OP_SHL: begin
        // The upper half of the widened shift holds every bit pushed out.
        if (shl_big) begin
          alu_res   = '0;
          alu_carry = |ALUout;
        end else begin
          alu_res   = shl_ext[ACC_W-1:0];
          alu_carry = |shl_ext[2*ACC_W-1:ACC_W];
        end
      end
      OP_HOLD: begin
        alu_res   = ALUout;
        alu_carry = Carry;
      end
      default: begin
        alu_res   = ALUout;
        alu_carry = Carry;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Accumulator, flags and multiplier registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all registers
  //       update together from pre-edge values.
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      ALUout       <= '0;
      Carry        <= 1'b0;
      Result_valid <= 1'b0;
      mul_mcand    <= '0;
      mul_mplier   <= '0;
      mul_prod     <= '0;
      mul_cnt      <= '0;
    end else begin
      Result_valid <= 1'b0;
      if (accept) begin
        if (is_mul) begin
          // ALUout holds until the product is complete.
          mul_mcand  <= {{DATA_W{1'b0}}, op_a};
          mul_mplier <= Data;
          mul_prod   <= '0;
          mul_cnt    <= '0;
        end else begin
          ALUout       <= alu_res;
          Carry        <= alu_carry;
          Result_valid <= 1'b1;
        end
      end else if (state == ST_MUL) begin
        mul_prod   <= mul_prod_step;
        mul_mcand  <= mul_mcand << 1;
        mul_mplier <= mul_mplier >> 1;
        mul_cnt    <= mul_cnt + CNT_W'(1);
        if (mul_last) begin
          ALUout       <= mul_prod_step;
          Carry        <= 1'b0;
          Result_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_accum_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_accum_seq
//
// Scoreboard bench for alu_accum_seq (DATA_W = 4). The driver updates an
// arithmetic reference model on every accepted op and queues the expected
// result with the cycle in which Result_valid must appear. A separate monitor
// pops and compares on every Result_valid pulse. Directed scenarios are
// followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_alu_accum_seq;

  localparam int DW = 4;
  localparam int AW = 2 * DW;
  localparam longint unsigned MASK  = (64'd1 << AW) - 1;
  localparam longint unsigned LMASK = (64'd1 << DW) - 1;

  localparam logic [2:0] F_ADD  = 3'b000;
  localparam logic [2:0] F_SUB  = 3'b001;
  localparam logic [2:0] F_SEXT = 3'b010;
  localparam logic [2:0] F_OR   = 3'b011;
  localparam logic [2:0] F_AND  = 3'b100;
  localparam logic [2:0] F_SHL  = 3'b101;
  localparam logic [2:0] F_MUL  = 3'b110;
  localparam logic [2:0] F_HOLD = 3'b111;

  logic          Clock;
  logic          Reset_b;
  logic [DW-1:0] Data;
  logic [2:0]    Function;
  logic          Op_valid;
  logic          Op_ready;
  logic [AW-1:0] ALUout;
  logic          Result_valid;
  logic          Carry;
  logic          Zero;

  alu_accum_seq #(.DATA_W(DW)) dut (
    .Clock        (Clock),
    .Reset_b      (Reset_b),
    .Data         (Data),
    .Function     (Function),
    .Op_valid     (Op_valid),
    .Op_ready     (Op_ready),
    .ALUout       (ALUout),
    .Result_valid (Result_valid),
    .Carry        (Carry),
    .Zero         (Zero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  longint cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    longint unsigned acc;
    bit              carry;
    longint          due;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  longint unsigned m_acc   = 0;
  bit              m_carry = 0;

  task automatic check(input string name, input longint unsigned got,
                       input longint unsigned want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: the specification's rules in plain integer arithmetic.
  function automatic void model_apply(input logic [2:0] f, input longint unsigned d);
    longint unsigned a;
    longint unsigned s;
    longint unsigned full;
    a = m_acc & LMASK;
    case (f)
      F_ADD: begin
        s = a + d;
        m_carry = (s >= (64'd1 << DW));
`ifdef ALU_SAT_EN
        m_acc = m_carry ? LMASK : s;
`else
        m_acc = s;
`endif
      end
      F_SUB: begin
        m_carry = (a < d);
`ifdef ALU_SAT_EN
        m_acc = m_carry ? 0 : a - d;
`else
        m_acc = (a - d) & MASK;   // negative differences wrap in 2*DW bits
`endif
      end
      F_SEXT: begin
        m_acc   = (a >= (64'd1 << (DW - 1))) ? ((a + MASK + 1 - (64'd1 << DW)) & MASK) : a;
        m_carry = 0;
      end
      F_OR:  begin m_acc = ((a | d) != 0) ? 1 : 0; m_carry = 0; end
      F_AND: begin m_acc = ((a & d) != 0) ? 1 : 0; m_carry = 0; end
      F_SHL: begin
        if (d >= AW) begin
          m_carry = (m_acc != 0);
          m_acc   = 0;
        end else begin
          full    = m_acc << d;
          m_carry = ((full >> AW) != 0);
          m_acc   = full & MASK;
        end
      end
      F_MUL: begin m_acc = a * d; m_carry = 0; end
      default: ;  // HOLD
    endcase
  endfunction

  // Called at posedge+1. Presents one cycle of stimulus, updates the model
  // when the op is accepted, and returns at the next posedge+1.
  task automatic cycle_op(input bit v, input logic [2:0] f, input logic [DW-1:0] d,
                          output bit accepted, output longint acc_cyc);
    exp_t e;
    Op_valid = v;
    Function = f;
    Data     = d;
    accepted = v && Op_ready;
    acc_cyc  = cyc + 1;
    if (accepted) begin
      model_apply(f, longint'(d));
      e.acc   = m_acc;
      e.carry = m_carry;
      e.due   = acc_cyc + ((f == F_MUL) ? DW : 0);
      exp_q.push_back(e);
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic op(input logic [2:0] f, input logic [DW-1:0] d);
    bit     a;
    longint c;
    cycle_op(1'b1, f, d, a, c);
    Op_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit     a;
    longint c;
    for (int i = 0; i < n; i++) cycle_op(1'b0, F_HOLD, '0, a, c);
  endtask

  // Asserts reset in the middle of a cycle and checks the immediate effect.
  task automatic do_reset();
    Op_valid = 1'b0;
    #2;
    Reset_b = 1'b0;
    #1;
    check("reset_aluout", ALUout, 0);
    check("reset_ready", Op_ready, 1);
    check("reset_zero", Zero, 1);
    check("reset_carry", Carry, 0);
    check("reset_rvalid", Result_valid, 0);
    exp_q.delete();
    m_acc   = 0;
    m_carry = 0;
    Reset_b = 1'b1;
    @(posedge Clock);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge Clock) begin
    exp_t e;
    if (Reset_b && Result_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_aluout", ALUout, e.acc);
        check("sb_carry", Carry, e.carry);
        check("sb_zero", Zero, (e.acc == 0));
        check("sb_latency", cyc, e.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit     a;
    longint c1;
    longint c2;

    Reset_b  = 1'b0;
    Op_valid = 1'b0;
    Function = F_HOLD;
    Data     = '0;
    @(posedge Clock);
    #1;
    Reset_b = 1'b1;
    do_reset();

    // ADD chain with carry out of the low half
    op(F_ADD, 4'h5);
    check("add5_aluout", ALUout, 8'h05);
    check("add5_carry", Carry, 0);
    op(F_ADD, 4'hF);
    check("addF_aluout", ALUout, 8'h14);
    check("addF_carry", Carry, 1);
    idle(1);

    // SUB with borrow, then idle cycles must hold
    do_reset();
    op(F_ADD, 4'h3);
    op(F_SUB, 4'h5);
    check("sub_aluout", ALUout, 8'hFE);
    check("sub_carry", Carry, 1);
    check("sub_zero", Zero, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("idle_hold", ALUout, 8'hFE);
    end

    // MUL with Op_valid held high: busy for DW cycles, back-to-back accept
    do_reset();
    op(F_ADD, 4'hD);
    cycle_op(1'b1, F_MUL, 4'hB, a, c1);
    check("mul_accept", a, 1);
    for (int i = 0; i < DW; i++) begin
      check("mul_busy_ready", Op_ready, 0);
      check("mul_busy_hold", ALUout, 8'h0D);
      cycle_op(1'b1, F_MUL, 4'hB, a, c2);
    end
    check("mul_product", ALUout, 8'h8F);
    check("mul_done_ready", Op_ready, 1);
    cycle_op(1'b1, F_MUL, 4'hB, a, c2);
    check("mul_reaccept", a, 1);
    check("mul_reaccept_edge", c2 - c1, DW + 1);
    Op_valid = 1'b0;
    idle(DW + 2);

    // SHL with shift-out carry, then an oversize shift
    do_reset();
    op(F_SUB, 4'hF);          // 0 - 15 -> 0xF1
    op(F_SHL, 4'h1);
    check("shl1_aluout", ALUout, 8'hE2);
    check("shl1_carry", Carry, 1);
    op(F_SHL, 4'h8);
    check("shl8_aluout", ALUout, 8'h00);
    check("shl8_carry", Carry, 1);
    check("shl8_zero", Zero, 1);
    idle(1);

    // Reset in the middle of a multiply aborts it
    do_reset();
    op(F_ADD, 4'h5);
    op(F_MUL, 4'h3);
    idle(1);
    do_reset();
    idle(6);
    op(F_ADD, 4'h1);
    check("post_abort_add", ALUout, 8'h01);
    idle(1);

    // ADD overflow: saturating or wrapping depending on build
    do_reset();
    op(F_ADD, 4'hF);
    op(F_ADD, 4'h3);
`ifdef ALU_SAT_EN
    check("sat_add_aluout", ALUout, 8'h0F);
`else
    check("wrap_add_aluout", ALUout, 8'h12);
`endif
    check("ovf_add_carry", Carry, 1);
    idle(1);

    // Randomized traffic, including Op_valid toggling during MUL
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle_op(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
               DW'($urandom_range(0, (1 << DW) - 1)), a, c1);
    end
    Op_valid = 1'b0;
    idle(DW + 4);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_accum_seq.md
Name:
alu_accum_seq

Overview:
- Parametrised successor to the lab-4 registered accumulator ALU.
- The register feeds its low half back as operand A; the external `Data` bus supplies operand B.
- Adds a valid/ready op handshake, a multi-cycle shift-add multiplier FSM, subtract, and carry/zero status flags.
- Sits between switch/button input logic and the hex-display drivers.

Parameters:
- DATA_W, 4, operand width; the accumulator is 2*DATA_W bits; must be >= 2.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_b  in  1  asynchronous active-low reset.
- Data  in  DATA_W  operand B.
- Function  in  3  operation select.
- Op_valid  in  1  operation request.
- Op_ready  out  1  block can accept an op this cycle.
- ALUout  out  2*DATA_W  accumulator register.
- Result_valid  out  1  one-cycle pulse after each ALUout write.
- Carry  out  1  carry/borrow/shift-out flag.
- Zero  out  1  high when ALUout == 0.

Behaviour:
- Interface: one clock, `Clock`. Reset `Reset_b` is asynchronous and active-low.
- Reset (immediate, independent of Clock):
  - ALUout=0, Result_valid=0, Carry=0, Zero=1.
  - FSM goes to IDLE, Op_ready=1, iteration counter=0.
- Reset asserted mid-multiply aborts the multiply; no Result_valid is produced.
- Definitions: A = ALUout[DATA_W-1:0]. An op is accepted on a rising edge with Op_valid && Op_ready.
- No accept means ALUout and flags hold, and Result_valid=0 next cycle. ALUout no longer updates every cycle.
- Single-cycle ops write ALUout at the accept edge. Result_valid is high for exactly the following cycle:
  - 000 ADD: {0, A+Data}. (DATA_W+1)-bit sum zero-extended to 2*DATA_W. Carry = bit DATA_W of the sum.
  - 001 SUB: A-Data as a (DATA_W+1)-bit two's-complement difference, sign-extended to 2*DATA_W. Carry = borrow (A<Data).
  - 010 SEXT: A sign-extended to 2*DATA_W. Carry=0.
  - 011 OR-test: 1 if (A|Data)!=0, else 0. Carry=0.
  - 100 AND-test: 1 if (A&Data)!=0, else 0. Carry=0.
  - 101 SHL: ALUout << Data. Result is 0 when Data >= 2*DATA_W. Carry = OR of all bits shifted out.
  - 111 HOLD: ALUout unchanged. Carry unchanged. Still pulses Result_valid.
- Zero is recomputed from the new ALUout on every write.
- 110 MUL (unsigned A*Data): FSM IDLE -> MUL.
  - At the accept edge: latch A and Data into internal operand registers, clear the partial product, counter=0.
  - In MUL: Op_ready=0. Each edge does one shift-add iteration and increments the counter.
  - At edge DATA_W after accept: ALUout <= 2*DATA_W-bit product, Carry=0, Zero updated, FSM -> IDLE, Result_valid pulses next cycle.
  - ALUout holds its old value during MUL.
  - Op_valid and Data changes during MUL are ignored.
  - First new accept is possible at edge DATA_W+1.
- Op_ready is combinational from FSM state: 1 in IDLE, 0 in MUL.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: ADD saturates to 2^DATA_W-1 when the sum >= 2^DATA_W, and Carry is still 1. SUB clamps to 0 when A<Data, with no sign extension, and Carry is still 1.
- Undefined: ADD and SUB behave exactly as listed above (wrapping/extending).

Test Plan:
All scenarios use DATA_W=4.
- Reset; ADD Data=5 -> ALUout=0x05, Carry=0. Then ADD Data=0xF -> ALUout=0x14, Carry=1, Result_valid one cycle after each accept.
- ALUout=0x03; SUB Data=5 -> ALUout=0xFE, Carry=1, Zero=0. Then idle 3 cycles with Op_valid=0 -> ALUout stays 0xFE, Result_valid=0.
- ALUout=0x0D; MUL Data=0xB with Op_valid held high -> Op_ready=0 for 4 cycles, ALUout=0x0D until edge 4, then 0x8F. Result_valid single pulse; next MUL accepted at edge 5.
- ALUout=0x81; SHL Data=1 -> 0x02, Carry=1. Then SHL Data=8 -> 0x00, Carry=1, Zero=1.
- MUL started; Reset_b pulsed low mid-cycle 2 -> ALUout=0 before the next edge, Op_ready=1, no Result_valid, next ADD Data=1 -> 0x01.
- ALUout=0x0F; ADD Data=3 -> with ALU_SAT_EN: 0x0F, Carry=1. Without ALU_SAT_EN: 0x12, Carry=1.
